// File: rtl/dm_responder.sv
// Data-memory responder: word-addressed RAM behind the CPU load/store strobes,
// with programmable wait states, a busy stall and one-cycle ready/error pulses.
module dm_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  do_dm_read,
  input  logic                  do_dm_write,
  input  logic [31:0]           dm_address,
  input  logic [DATA_WIDTH-1:0] dm_in_data,
  output logic [DATA_WIDTH-1:0] dm_out_data,
  output logic                  dm_busy,
  output logic                  dm_ready,
  output logic                  dm_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;

  state_t                state_r;
  state_t                state_next_s;
  logic [3:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  rd_r;
  logic                  wr_r;
  logic                  err_r;

  logic                  req_s;
  logic                  take_s;
  logic                  enter_done_s;
  logic [ADDR_WIDTH-1:0] acc_idx_s;
  logic [DATA_WIDTH-1:0] acc_data_s;
  logic                  acc_rd_s;
  logic                  acc_wr_s;
  logic                  acc_err_s;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Misaligned, beyond the array, or conflicting read+write strobes.
  function automatic logic addr_error_f(input logic [31:0] addr,
                                        input logic        rd,
                                        input logic        wr);
    return (addr[1:0] != 2'b00) ||
           ((addr >> (ADDR_WIDTH + 2)) != 32'd0) ||
           (rd && wr);
  endfunction

  assign req_s        = do_dm_read | do_dm_write;
  assign take_s       = (state_r == IDLE) && req_s;
  assign enter_done_s = (state_next_s == DONE);

  // Access operands: live inputs when DONE is entered straight from IDLE, latched copy otherwise.
  always_comb begin
    acc_idx_s  = idx_r;
    acc_data_s = data_r;
    acc_rd_s   = rd_r;
    acc_wr_s   = wr_r;
    acc_err_s  = err_r;
    if (state_r == IDLE) begin
      acc_idx_s  = dm_address[ADDR_WIDTH+1:2];
      acc_data_s = dm_in_data;
      acc_rd_s   = do_dm_read;
      acc_wr_s   = do_dm_write;
      acc_err_s  = addr_error_f(dm_address, do_dm_read, do_dm_write);
    end else begin
      acc_idx_s  = idx_r;
      acc_data_s = data_r;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (WAIT_CYCLES > 0) begin
            state_next_s = WAIT;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Stall while a request waits to be sampled and throughout the wait states.
  always_comb begin
    dm_busy = 1'b0;
    if ((state_r == WAIT) || take_s) begin
      dm_busy = 1'b1;
    end else begin
      dm_busy = 1'b0;
    end
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r  <= 4'd0;
      idx_r  <= '0;
      data_r <= '0;
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
      err_r  <= 1'b0;
    end else if (take_s) begin
      cnt_r  <= WAIT_LOAD;
      idx_r  <= dm_address[ADDR_WIDTH+1:2];
      data_r <= dm_in_data;
      rd_r   <= do_dm_read;
      wr_r   <= do_dm_write;
      err_r  <= addr_error_f(dm_address, do_dm_read, do_dm_write);
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered completion outputs; load data lands together with the ready pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      dm_out_data <= '0;
      dm_ready    <= 1'b0;
      dm_error    <= 1'b0;
    end else begin
      dm_ready <= enter_done_s;
      dm_error <= enter_done_s && acc_err_s;
      if (enter_done_s && (acc_rd_s || acc_err_s)) begin
        dm_out_data <= acc_err_s ? '0 : mem_r[acc_idx_s];
      end else begin
        dm_out_data <= dm_out_data;
      end
    end
  end

  // Store commit; a reset on the committing edge cancels the write.
  always_ff @(posedge clock) begin
    if (!reset && enter_done_s && acc_wr_s && !acc_err_s) begin
      mem_r[acc_idx_s] <= acc_data_s;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: one instance with two wait states (a)
// and one with none (b), compared against a transaction-level memory model.
module tb_dm_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] addr_a, addr_b, din_a, din_b;
  logic [31:0] dout_a, dout_b;
  logic        busy_a, busy_b, rdy_a, rdy_b, err_a, err_b;

  dm_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset), .do_dm_read(rd_a), .do_dm_write(wr_a),
    .dm_address(addr_a), .dm_in_data(din_a), .dm_out_data(dout_a),
    .dm_busy(busy_a), .dm_ready(rdy_a), .dm_error(err_a));

  dm_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .do_dm_read(rd_b), .do_dm_write(wr_b),
    .dm_address(addr_b), .dm_in_data(din_b), .dm_out_data(dout_b),
    .dm_busy(busy_b), .dm_ready(rdy_b), .dm_error(err_b));

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model: sparse word memories and the expected load-data register.
  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];
  logic [31:0] out_exp   [2];
  bit          out_known [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_err(input logic rd, input logic wr, input logic [31:0] addr);
    return (addr % 32'd4 != 32'd0) || (addr >= 32'd4096) || (rd && wr);
  endfunction

  function automatic logic o_busy(input int s); return (s == 0) ? busy_a : busy_b; endfunction
  function automatic logic o_rdy (input int s); return (s == 0) ? rdy_a  : rdy_b;  endfunction
  function automatic logic o_err (input int s); return (s == 0) ? err_a  : err_b;  endfunction
  function automatic logic [31:0] o_out(input int s); return (s == 0) ? dout_a : dout_b; endfunction

  function automatic bit mem_has(input int s, input int idx);
    return (s == 0) ? mem_a.exists(idx) : mem_b.exists(idx);
  endfunction
  function automatic logic [31:0] mem_get(input int s, input int idx);
    return (s == 0) ? mem_a[idx] : mem_b[idx];
  endfunction

  task automatic mem_put(input int s, input int idx, input logic [31:0] d);
    if (s == 0) mem_a[idx] = d;
    else        mem_b[idx] = d;
  endtask

  task automatic drive(input int s, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (s == 0) begin
      rd_a = rd; wr_a = wr; addr_a = addr; din_a = data;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = addr; din_b = data;
    end
  endtask

  // One transaction; returns at the negedge of the ready cycle with the request still held.
  task automatic run_op(input int s, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit from_done, input string tag);
    int w   = (s == 0) ? 2 : 0;
    bit e   = mdl_err(rd, wr, addr);
    int idx = int'(addr >> 2);
    int lat = 0;
    bit got = 1'b0;
    drive(s, rd, wr, addr, data);
    if (from_done) @(negedge clock);
    else #1;
    check({tag, ".busy_req"}, 32'(o_busy(s)), 32'd1);
    @(posedge clock);
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clock);
      if (o_rdy(s)) begin
        got = 1'b1;
        lat = k;
      end else begin
        check({tag, ".busy_wait"}, 32'(o_busy(s)), 32'd1);
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(w + 1));
    if (got) begin
      check({tag, ".error"}, 32'(o_err(s)), 32'(e));
      check({tag, ".busy_done"}, 32'(o_busy(s)), 32'd0);
      if (!e && wr) mem_put(s, idx, data);
      if (e) begin
        out_exp[s]   = 32'd0;
        out_known[s] = rd;
      end else if (rd) begin
        out_known[s] = mem_has(s, idx);
        out_exp[s]   = out_known[s] ? mem_get(s, idx) : 32'd0;
      end
      if (out_known[s]) check({tag, ".rdata"}, o_out(s), out_exp[s]);
    end
  endtask

  task automatic idle(input int s, input string tag);
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check({tag, ".idle_ready"}, 32'(o_rdy(s)), 32'd0);
    check({tag, ".idle_busy"}, 32'(o_busy(s)), 32'd0);
    if (out_known[s]) check({tag, ".hold"}, o_out(s), out_exp[s]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] raddr;
    logic        rrd, rwr;
    int          r;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    out_exp[0] = 32'd0; out_exp[1] = 32'd0;
    out_known[0] = 1'b1; out_known[1] = 1'b1;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      check("rst.out",   o_out(s),          32'd0);
      check("rst.ready", 32'(o_rdy(s)),     32'd0);
      check("rst.error", 32'(o_err(s)),     32'd0);
      check("rst.busy",  32'(o_busy(s)),    32'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    run_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "sw10");
    idle(0, "sw10");
    run_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "lw10");
    idle(0, "lw10");
    idle(0, "lw10b");

    run_op(0, 1'b0, 1'b1, 32'h0, 32'h11112222, 1'b0, "sw0");
    idle(0, "sw0");
    run_op(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0, "lw12_misal");
    idle(0, "lw12_misal");
    run_op(0, 1'b0, 1'b1, 32'h1000, 32'h00000BAD, 1'b0, "sw1000_oor");
    idle(0, "sw1000_oor");
    run_op(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "lw0");
    idle(0, "lw0");

    run_op(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, "both");
    idle(0, "both");
    run_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "lw10_after_both");
    idle(0, "lw10_after_both");

    // Reset lands on the edge that would commit the store to 0x20.
    run_op(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, "sw20_prior");
    idle(0, "sw20_prior");
    drive(0, 1'b0, 1'b1, 32'h20, 32'h00000055);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid.ready", 32'(rdy_a), 32'd0);
    check("rstmid.out", dout_a, 32'd0);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    out_exp[0] = 32'd0; out_exp[1] = 32'd0;
    out_known[0] = 1'b1; out_known[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rstmid.no_ready", 32'(rdy_a), 32'd0);
      check("rstmid.busy", 32'(busy_a), 32'd0);
    end
    run_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "lw20_after_rst");
    idle(0, "lw20_after_rst");

    // Zero wait states, back-to-back stream.
    run_op(1, 1'b0, 1'b1, 32'h0,    32'h00000001, 1'b0, "w0.sw0");
    run_op(1, 1'b1, 1'b0, 32'h0,    32'h0,        1'b1, "w0.lw0");
    run_op(1, 1'b0, 1'b1, 32'h4,    32'h00000002, 1'b1, "w0.sw4");
    run_op(1, 1'b1, 1'b0, 32'h4,    32'h0,        1'b1, "w0.lw4");
    run_op(1, 1'b1, 1'b0, 32'h6,    32'h0,        1'b1, "w0.lw6");
    run_op(1, 1'b0, 1'b1, 32'h1000, 32'h00000003, 1'b1, "w0.sw1000");
    run_op(1, 1'b1, 1'b0, 32'h3FFC, 32'h0,        1'b1, "w0.lwtop");
    idle(1, "w0.end");

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        r   = int'($urandom_range(0, 9));
        rrd = 1'($urandom_range(0, 1));
        rwr = !rrd;
        raddr = 32'($urandom_range(0, 15)) << 2;
        if (r == 7) raddr = raddr | 32'($urandom_range(1, 3));
        else if (r == 8) raddr = raddr | (32'($urandom_range(1, 255)) << 12);
        else if (r == 9) begin rrd = 1'b1; rwr = 1'b1; end
        run_op(s, rrd, rwr, raddr, $urandom, (i % 8) != 0, "rand");
        if (i % 8 == 7) idle(s, "rand");
      end
      idle(s, "rand_end");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the CPU's load/store path. It serves the data-memory read and write strobes that the CPU controller raises for LWI/SWI/LW/SW, plus the address and store data from the datapath.
- Holds a word-addressed storage array, inserts a configurable number of wait states, and stalls the CPU with a busy signal. Completion is reported with a one-cycle ready pulse and an error flag.
- Sits between the CPU datapath and on-chip data RAM.

Parameters:
ADDR_WIDTH, 10, word-index width; memory depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, data word width
WAIT_CYCLES, 2, wait states inserted before completion; legal range 0..15

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
do_dm_read  input  1  load request from the CPU controller; held high until completion
do_dm_write  input  1  store request from the CPU controller; held high until completion
dm_address  input  32  byte address from the ALU result
dm_in_data  input  DATA_WIDTH  store data (rt register value)
dm_out_data  output  DATA_WIDTH  load data
dm_busy  output  1  stall request to the CPU pipeline
dm_ready  output  1  one-cycle completion pulse
dm_error  output  1  one-cycle error pulse, coincident with dm_ready

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports named clock and reset).
- Reset values: state=IDLE, wait counter=0, dm_out_data=0, dm_ready=0, dm_error=0, dm_busy=0. Memory array contents are not reset.
- State machine: IDLE, WAIT, DONE.
- IDLE:
  - A request is do_dm_read|do_dm_write, sampled at the clock edge.
  - On a request, latch address, data, op and the error condition.
  - Load counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go to DONE.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, go to DONE at the next edge.
  - WAIT lasts exactly WAIT_CYCLES cycles.
- DONE:
  - Lasts one cycle; dm_ready=1 and dm_error=error flag.
  - Next state is always IDLE.
- Memory access on the edge entering DONE:
  - Write: mem[idx] <= latched data.
  - Read: dm_out_data <= mem[idx], so load data is valid while dm_ready is high.
- Latency: dm_ready is high WAIT_CYCLES+1 cycles after the sampling edge. Back-to-back accesses are separated by one IDLE cycle.
- dm_busy (combinational):
  - 1 in IDLE while a request is present, and 1 throughout WAIT.
  - 0 in DONE, so the CPU advances on the DONE edge.
  - 0 in IDLE with no request.
- Address rules:
  - idx = dm_address[ADDR_WIDTH+1:2].
  - Error if dm_address[1:0]!=0, or dm_address[31:ADDR_WIDTH+2] is nonzero, or read and write are both high.
  - On error: no memory write, dm_out_data <= 0, dm_error=1 in DONE.
- dm_out_data holds its value except on a read completion (data or 0 on error).
- Request inputs are ignored outside IDLE: changes in WAIT/DONE do not affect the latched operation.
- Reset mid-operation: reset wins over every transition.
  - State returns to IDLE and outputs go to their reset values.
  - A write whose DONE-entry edge coincides with reset is not committed.
- A request dropped before completion is still completed, with its ready pulse.

Test Plan:
1. Reset, then SW to address 0x10 with data 0xDEADBEEF (WAIT_CYCLES=2) -> dm_busy high 3 cycles; dm_ready pulses on cycle 3 after sampling; dm_error=0.
2. Then LW from 0x10 -> dm_out_data=0xDEADBEEF coincident with dm_ready; dm_out_data holds afterwards with no request.
3. LW from 0x12 (misaligned) and SW to 0x00001000 (out of range for ADDR_WIDTH=10) -> dm_error=1 with dm_ready. The store leaves mem[0] unchanged, checked by a later LW from 0x0. The misaligned read returns 0.
4. do_dm_read and do_dm_write both high -> dm_error=1, no write, dm_out_data=0.
5. Assert reset on the cycle before DONE of an SW 0x55 to address 0x20 -> state IDLE, dm_ready never pulses. A later LW from 0x20 returns the prior contents.
6. Rebuild with WAIT_CYCLES=0: back-to-back LW/SW stream -> dm_ready one cycle after each sampling edge; dm_busy high only during the IDLE request cycle.
